// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned shift-add multiplier built around one shared 8-bit ripple adder.
// Optional build macro MUL8_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.

// adder8: 8-bit ripple-carry adder.
// Latency: combinational.
// Backpressure: none.
module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);
    logic [8:0] c;

    assign c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_fa
            assign s[i]   = a[i] ^ b[i] ^ c[i];
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = c[8];
endmodule

// mul8_seq: shift-add multiplier, one adder8 step per cycle.
// Latency: 8 cycles from accepted start to done (fewer with early exit).
// Backpressure: start is ignored while busy; result held in p until the next accept.
module mul8_seq #(
    parameter int DONE_PULSE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic        busy,
    output logic        done,
    output logic [15:0] p
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  a;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [2:0]  cnt;

    logic        accept;
    logic        finish;
    logic [7:0]  add_b;
    logic [7:0]  sum_s;
    logic        sum_c;
    logic [15:0] step_val;
    logic [15:0] final_val;

    assign accept = start && (state != S_RUN);
    assign add_b  = lo[0] ? a : 8'h00;

    adder8 u_add (
        .a    (hi),
        .b    (add_b),
        .cin  (1'b0),
        .s    (sum_s),
        .cout (sum_c)
    );

    // Carry lands in hi[7] on the shift, so the 16-bit product never overflows.
    assign step_val = {sum_c, sum_s, lo[7:1]};

`ifdef MUL8_EARLY_EXIT_EN
    logic [7:0]  rem_mask;
    logic        skip;
    logic [15:0] shifted;

    assign rem_mask  = 8'hFF >> cnt;
    assign skip      = ((lo & rem_mask) == 8'h00);
    assign shifted   = {hi, lo} >> (4'd8 - {1'b0, cnt});
    assign finish    = skip || (cnt == 3'd7);
    assign final_val = skip ? shifted : step_val;
`else
    assign finish    = (cnt == 3'd7);
    assign final_val = step_val;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_RUN;
            end
            S_RUN: begin
                if (finish) state_nx = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    state_nx = S_RUN;
                end else if (DONE_PULSE != 0) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a    <= 8'h00;
            hi   <= 8'h00;
            lo   <= 8'h00;
            cnt  <= 3'd0;
            done <= 1'b0;
            p    <= 16'h0000;
        end else if (accept) begin
            a    <= x;
            hi   <= 8'h00;
            lo   <= y;
            cnt  <= 3'd0;
            done <= 1'b0;
        end else if (state == S_RUN) begin
            {hi, lo} <= step_val;
            cnt      <= cnt + 3'd1;
            if (finish) begin
                p    <= final_val;
                done <= 1'b1;
            end
        end else if ((state == S_DONE) && (DONE_PULSE != 0)) begin
            done <= 1'b0;
        end
    end

    assign busy = (state == S_RUN);
endmodule
